// File: rtl/serial_to_parallel_fifo.sv
// ============================================================================
// Module      : serial_to_parallel_fifo
// Description : MSB-first serial-to-parallel word assembler feeding a
//               DEPTH-entry FIFO with valid/ready output, frame-error pulse
//               and sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_to_parallel_fifo #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       i_clock,
    input  logic                       i_reset_n,
    input  logic                       i_enable,
    input  logic                       i_valid,
    input  logic                       i_data,
    input  logic                       i_ready,
    input  logic                       i_clear,
    output logic                       o_valid,
    output logic [N-1:0]               o_word,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic                       o_frame_err,
    output logic                       o_overflow
);

    localparam int CW = $clog2(N);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    localparam logic [CW-1:0] c_cnt_last = CW'(N-1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);
    localparam logic [PW-1:0] c_ptr_one  = PW'(1);
    localparam logic [LW-1:0] c_lvl_one  = LW'(1);
    localparam logic [LW-1:0] c_lvl_full = LW'(DEPTH);

    logic [CW-1:0]  r_cnt;
    logic [N-2:0]   r_sh;
    logic [N-1:0]   r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [LW-1:0]  r_level;
    logic           r_frame_err;
    logic           r_overflow;

    logic           w_bit;
    logic           w_word_done;
    logic           w_full;
    logic           w_pop;
    logic           w_push;
    logic           w_drop;
    logic [N-1:0]   w_new_word;

    assign w_bit       = i_enable & i_valid;
    assign w_word_done = w_bit & (r_cnt == c_cnt_last);
    assign w_new_word  = {r_sh, i_data};
    assign w_full      = (r_level == c_lvl_full);
    assign w_pop       = (r_level != '0) & i_ready;
    // A full FIFO can still take a word when the head leaves on the same edge.
    assign w_push      = w_word_done & (~w_full | w_pop);
    assign w_drop      = w_word_done & w_full & ~w_pop;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_cnt       <= '0;
            r_sh        <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= i_enable & ~i_valid & (r_cnt != '0);
            if (!i_enable || !i_valid || w_word_done) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
            if (w_bit) begin
                r_sh <= w_new_word[N-2:0];
            end
        end
    end

    // Storage needs no reset: entries are only visible while r_level covers them.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_new_word;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_valid     = (r_level != '0);
    assign o_word      = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_level     = r_level;
    assign o_frame_err = r_frame_err;
    assign o_overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_serial_to_parallel_fifo.sv
// ============================================================================
// Module      : tb_serial_to_parallel_fifo
// Description : Directed self-checking bench for serial_to_parallel_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_to_parallel_fifo;

    logic       clk;
    logic       i_reset_n;
    logic       i_enable;
    logic       i_valid;
    logic       i_data;
    logic       i_ready;
    logic       i_clear;
    logic       o_valid;
    logic [7:0] o_word;
    logic [2:0] o_level;
    logic       o_frame_err;
    logic       o_overflow;

    int tests_run;
    int tests_failed;

    serial_to_parallel_fifo #(
        .N     (8),
        .DEPTH (4)
    ) u_dut (
        .i_clock     (clk),
        .i_reset_n   (i_reset_n),
        .i_enable    (i_enable),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_ready     (i_ready),
        .i_clear     (i_clear),
        .o_valid     (o_valid),
        .o_word      (o_word),
        .o_level     (o_level),
        .o_frame_err (o_frame_err),
        .o_overflow  (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        i_valid = 1'b1;
        i_data  = b;
        tick();
    endtask

    // Leaves i_valid high so consecutive calls form a continuous strobe.
    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i]);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        i_reset_n = 1'b0;
        i_enable  = 1'b1;
        i_valid   = 1'b0;
        i_data    = 1'b0;
        i_ready   = 1'b0;
        i_clear   = 1'b0;
        tick();
        tick();
        chk("rst_valid", o_valid, 0);
        chk("rst_word", o_word, 0);
        chk("rst_level", o_level, 0);
        chk("rst_ferr", o_frame_err, 0);
        chk("rst_ovf", o_overflow, 0);
        i_reset_n = 1'b1;
        tick();

        // 1: single word, consumer always ready
        i_ready = 1'b1;
        send_word(8'hB2);
        chk("t1_valid", o_valid, 1);
        chk("t1_word", o_word, 8'hB2);
        chk("t1_level", o_level, 1);
        i_valid = 1'b0;
        tick();
        chk("t1_popped", o_valid, 0);
        chk("t1_ferr", o_frame_err, 0);

        // 2: back-to-back words, then drain
        i_ready = 1'b0;
        send_word(8'hA5);
        chk("t2_level1", o_level, 1);
        send_word(8'h3C);
        chk("t2_level2", o_level, 2);
        chk("t2_head", o_word, 8'hA5);
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        chk("t2_pop1_word", o_word, 8'h3C);
        chk("t2_pop1_level", o_level, 1);
        tick();
        chk("t2_pop2_valid", o_valid, 0);
        chk("t2_pop2_word", o_word, 0);
        chk("t2_ferr", o_frame_err, 0);

        // 3: overflow on the fifth word
        i_ready = 1'b0;
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h33);
        send_word(8'h44);
        chk("t3_level4", o_level, 4);
        chk("t3_ovf_pre", o_overflow, 0);
        send_word(8'h55);
        i_valid = 1'b0;
        chk("t3_level_full", o_level, 4);
        chk("t3_ovf_set", o_overflow, 1);
        chk("t3_head", o_word, 8'h11);
        tick();
        chk("t3_ovf_sticky", o_overflow, 1);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        chk("t3_ovf_clr", o_overflow, 0);

        // 5: full FIFO, pop coincides with a completed word
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        i_ready = 1'b1;
        send_bit(1'b0);
        i_valid = 1'b0;
        chk("t5_level", o_level, 4);
        chk("t5_ovf", o_overflow, 0);
        chk("t5_head22", o_word, 8'h22);
        tick();
        chk("t5_head33", o_word, 8'h33);
        tick();
        chk("t5_head44", o_word, 8'h44);
        tick();
        chk("t5_head66", o_word, 8'h66);
        tick();
        chk("t5_empty", o_valid, 0);

        // 4: short frame, then a good word
        i_ready = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("t4_ferr_pre", o_frame_err, 0);
        i_valid = 1'b0;
        tick();
        chk("t4_ferr_pulse", o_frame_err, 1);
        chk("t4_level", o_level, 0);
        tick();
        chk("t4_ferr_once", o_frame_err, 0);
        send_word(8'hC3);
        chk("t4_word", o_word, 8'hC3);
        chk("t4_level1", o_level, 1);

        // disable discards a partial word silently, FIFO retained
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        i_enable = 1'b0;
        tick();
        chk("en_ferr", o_frame_err, 0);
        tick();
        chk("en_ferr2", o_frame_err, 0);
        chk("en_level", o_level, 1);
        i_enable = 1'b1;
        i_valid  = 1'b0;
        tick();
        chk("en_ferr3", o_frame_err, 0);

        // 6: reset mid-word with words queued
        send_word(8'h5A);
        chk("t6_level2", o_level, 2);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        i_valid   = 1'b0;
        i_reset_n = 1'b0;
        tick();
        chk("t6_valid", o_valid, 0);
        chk("t6_word", o_word, 0);
        chk("t6_level", o_level, 0);
        chk("t6_ferr", o_frame_err, 0);
        chk("t6_ovf", o_overflow, 0);
        i_reset_n = 1'b1;
        tick();
        chk("t6_ferr_post", o_frame_err, 0);
        send_word(8'h96);
        i_valid = 1'b0;
        chk("t6_new_word", o_word, 8'h96);
        chk("t6_new_level", o_level, 1);
        i_ready = 1'b1;
        tick();
        chk("t6_drained", o_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
